bus_protocol_monitor: RTL

Passive testbench-side observer on the single-core SoC's shared bus, sitting beside the RAM slave and consuming the same resolved bus signals. It tracks each transaction (begin, data beats, end), checks it against the bus protocol, and reports per-transaction summaries and saturating statistics. It also latches the first protocol violation, so a simulation top can halt or print on failure.

---
 rtl/bus_protocol_monitor.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_protocol_monitor.sv
`timescale 1ns/1ps
// Passive bus observer: per-transaction summaries, saturating statistics and a first-violation latch.
// txn_done_o and counters update on the edge after end is sampled; never drives or stalls the bus.
module bus_protocol_monitor #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic [31:0]      bus_addrData_i,
   input  logic [3:0]       bus_byteEnables_i,
   input  logic [7:0]       bus_burstSize_i,
   input  logic             bus_readNWrite_i,
   input  logic             bus_beginTransaction_i,
   input  logic             bus_endTransaction_i,
   input  logic             bus_dataValid_i,
   input  logic             bus_busy_i,
   input  logic             bus_error_i,
   output logic             txn_done_o,
   output logic [31:0]      txn_addr_o,
   output logic             txn_rnw_o,
   output logic [8:0]       txn_beats_o,
   output logic [CNT_W-1:0] rd_count_o,
   output logic [CNT_W-1:0] wr_count_o,
   output logic [CNT_W-1:0] beat_count_o,
   output logic [CNT_W-1:0] berr_count_o,
   output logic             err_o,
   output logic [2:0]       err_code_o,
   output logic [31:0]      err_addr_o
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   localparam logic [2:0] E_STRAY_DATA      = 3'd1;
   localparam logic [2:0] E_STRAY_END       = 3'd2;
   localparam logic [2:0] E_NESTED_BEGIN    = 3'd3;
   localparam logic [2:0] E_OVERRUN         = 3'd4;
   localparam logic [2:0] E_BEAT_MISMATCH   = 3'd5;
   localparam logic [2:0] E_TIMEOUT         = 3'd6;
   localparam logic [2:0] E_BEGIN_COLLISION = 3'd7;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [0:0]       r_state;
   logic [31:0]      r_addr;
   logic             r_rnw;
   logic [8:0]       r_exp;
   logic [8:0]       r_beats;
   logic [TW-1:0]    r_timer;
   logic             r_done;
   logic [31:0]      r_txn_addr;
   logic             r_txn_rnw;
   logic [8:0]       r_txn_beats;
   logic [CNT_W-1:0] r_rd_cnt;
   logic [CNT_W-1:0] r_wr_cnt;
   logic [CNT_W-1:0] r_beat_cnt;
   logic [CNT_W-1:0] r_berr_cnt;
   logic             r_err;
   logic [2:0]       r_err_code;
   logic [31:0]      r_err_addr;

   logic [0:0]       w_state_nxt;
   logic [31:0]      w_addr_nxt;
   logic             w_rnw_nxt;
   logic [8:0]       w_exp_nxt;
   logic [8:0]       w_beats_nxt;
   logic [TW-1:0]    w_timer_nxt;
   logic             w_viol;
   logic [2:0]       w_code;
   logic [31:0]      w_vaddr;
   logic             w_done;
   logic             w_beat_inc;
   logic             w_berr_inc;
   logic             w_acc;
   logic [8:0]       w_exp_begin;
   logic             w_unused;

   // Byte enables are part of the observed bus but carry nothing this monitor checks.
   assign w_unused    = ^bus_byteEnables_i;
   assign w_acc       = bus_dataValid_i & ~bus_busy_i;
   assign w_exp_begin = {1'b0, bus_burstSize_i} + 9'd1;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_rnw_nxt   = r_rnw;
      w_exp_nxt   = r_exp;
      w_beats_nxt = r_beats;
      w_timer_nxt = r_timer;
      w_viol      = 1'b0;
      w_code      = 3'd0;
      w_vaddr     = 32'd0;
      w_done      = 1'b0;
      w_beat_inc  = 1'b0;
      w_berr_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus_beginTransaction_i) begin
               if (bus_dataValid_i || bus_endTransaction_i) begin
                  w_viol  = 1'b1;
                  w_code  = E_BEGIN_COLLISION;
                  w_vaddr = bus_addrData_i;
               end else begin
                  w_state_nxt = S_ACTIVE;
                  w_addr_nxt  = bus_addrData_i;
                  w_rnw_nxt   = bus_readNWrite_i;
                  w_exp_nxt   = w_exp_begin;
                  w_beats_nxt = 9'd0;
                  w_timer_nxt = '0;
               end
            end else if (bus_endTransaction_i) begin
               w_viol  = 1'b1;
               w_code  = E_STRAY_END;
               w_vaddr = bus_addrData_i;
            end else if (bus_dataValid_i) begin
               w_viol  = 1'b1;
               w_code  = E_STRAY_DATA;
               w_vaddr = bus_addrData_i;
            end
         end
         default: begin
            if (bus_error_i) begin
               w_berr_inc  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (bus_beginTransaction_i) begin
               w_viol      = 1'b1;
               w_code      = E_NESTED_BEGIN;
               w_vaddr     = r_addr;
               w_addr_nxt  = bus_addrData_i;
               w_rnw_nxt   = bus_readNWrite_i;
               w_exp_nxt   = w_exp_begin;
               w_beats_nxt = 9'd0;
               w_timer_nxt = '0;
            end else if (bus_endTransaction_i) begin
               // A beat accepted alongside end is counted before the length check.
               if (w_acc && r_beats == r_exp) begin
                  w_viol  = 1'b1;
                  w_code  = E_OVERRUN;
                  w_vaddr = r_addr;
               end else begin
                  if (w_acc) begin
                     w_beats_nxt = r_beats + 9'd1;
                     w_beat_inc  = 1'b1;
                  end
                  if (w_beats_nxt != r_exp) begin
                     w_viol  = 1'b1;
                     w_code  = E_BEAT_MISMATCH;
                     w_vaddr = r_addr;
                  end
               end
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_acc) begin
               w_timer_nxt = '0;
               if (r_beats == r_exp) begin
                  w_viol  = 1'b1;
                  w_code  = E_OVERRUN;
                  w_vaddr = r_addr;
               end else begin
                  w_beats_nxt = r_beats + 9'd1;
                  w_beat_inc  = 1'b1;
               end
            end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
               w_viol      = 1'b1;
               w_code      = E_TIMEOUT;
               w_vaddr     = r_addr;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_addr      <= 32'd0;
         r_rnw       <= 1'b0;
         r_exp       <= 9'd0;
         r_beats     <= 9'd0;
         r_timer     <= '0;
         r_done      <= 1'b0;
         r_txn_addr  <= 32'd0;
         r_txn_rnw   <= 1'b0;
         r_txn_beats <= 9'd0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_rnw   <= w_rnw_nxt;
         r_exp   <= w_exp_nxt;
         r_beats <= w_beats_nxt;
         r_timer <= w_timer_nxt;
         r_done  <= w_done;
         if (w_done) begin
            r_txn_addr  <= r_addr;
            r_txn_rnw   <= r_rnw;
            r_txn_beats <= w_beats_nxt;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_beat_cnt <= '0;
         r_berr_cnt <= '0;
         r_err      <= 1'b0;
         r_err_code <= 3'd0;
         r_err_addr <= 32'd0;
      end else if (clear_i) begin
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_beat_cnt <= '0;
         r_berr_cnt <= '0;
         r_err      <= 1'b0;
         r_err_code <= 3'd0;
         r_err_addr <= 32'd0;
      end else begin
         if (w_done && r_rnw)  r_rd_cnt   <= f_sat_inc(r_rd_cnt);
         if (w_done && !r_rnw) r_wr_cnt   <= f_sat_inc(r_wr_cnt);
         if (w_beat_inc)       r_beat_cnt <= f_sat_inc(r_beat_cnt);
         if (w_berr_inc)       r_berr_cnt <= f_sat_inc(r_berr_cnt);
         if (w_viol && !r_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_code;
            r_err_addr <= w_vaddr;
         end
      end
   end

   assign txn_done_o   = r_done;
   assign txn_addr_o   = r_txn_addr;
   assign txn_rnw_o    = r_txn_rnw;
   assign txn_beats_o  = r_txn_beats;
   assign rd_count_o   = r_rd_cnt;
   assign wr_count_o   = r_wr_cnt;
   assign beat_count_o = r_beat_cnt;
   assign berr_count_o = r_berr_cnt;
   assign err_o        = r_err;
   assign err_code_o   = r_err_code;
   assign err_addr_o   = r_err_addr;

endmodule
